// File: rtl/core_lsu_ctrl.sv
// Load/store sequencer between the EX stage and the data-memory bus: one op in flight,
// word-aligned bus request with byte lanes, sign/zero-extended load writeback.
module core_lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_load,
  input  logic               i_store,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [XLEN-1:0]    i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [XLEN-1:0]    o_mem_addr,
  output logic               o_mem_wen,
  output logic [XLEN-1:0]    o_mem_wdata,
  output logic [3:0]         o_mem_wstrb,
  input  logic               i_mem_rsp_valid,
  input  logic               i_mem_rsp_err,
  input  logic [XLEN-1:0]    i_mem_rdata,
  output logic               o_mem_rsp_ready,
  output logic               o_wb_valid,
  output logic [RFIDX_W-1:0] o_wb_rd_idx,
  output logic [XLEN-1:0]    o_wb_data,
  output logic               o_misalign,
  output logic               o_fault,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // EX->LSU (i_valid/o_ready) and the bus request (o_mem_req_valid/i_mem_req_ready)
  // hold their payload stable while valid is high and ready is low; the response
  // channel (i_mem_rsp_valid/o_mem_rsp_ready) is only consumed in WAIT.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         state;
  logic               op_load;
  logic [1:0]         op_size;
  logic               op_unsigned;
  logic [1:0]         op_off;
  logic [RFIDX_W-1:0] op_rd;

  logic            is_mem;
  logic            size_w;
  logic            misaligned;
  logic            accept;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_wstrb;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_data;

  assign o_ready         = (state == S_IDLE);
  assign o_mem_req_valid = (state == S_REQ);
  assign o_mem_rsp_ready = (state == S_WAIT);
  assign dbg_state       = state;

  always_comb begin
    is_mem     = i_load | i_store;
    size_w     = i_size[1];
    misaligned = ((i_size == 2'b01) & i_addr[0]) | (size_w & (i_addr[1:0] != 2'b00));
    accept     = i_valid & o_ready;
    lane_wdata = i_wdata;
    lane_wstrb = 4'b1111;
    case (i_size)
      2'b00: begin
        lane_wdata = {4{i_wdata[7:0]}};
        lane_wstrb = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{i_wdata[15:0]}};
        lane_wstrb = 4'b0011 << i_addr[1:0];
      end
      default: begin
        lane_wdata = i_wdata;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // The addressed byte/halfword is brought down to bit 0 before extension.
  always_comb begin
    rshift    = i_mem_rdata >> {op_off, 3'b000};
    load_data = i_mem_rdata;
    case (op_size)
      2'b00:   load_data = op_unsigned ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                       : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = op_unsigned ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                       : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      default: load_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_load     <= 1'b0;
      op_size     <= 2'b00;
      op_unsigned <= 1'b0;
      op_off      <= 2'b00;
      op_rd       <= '0;
      o_mem_addr  <= '0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= 4'b0000;
      o_wb_valid  <= 1'b0;
      o_wb_rd_idx <= '0;
      o_wb_data   <= '0;
      o_misalign  <= 1'b0;
      o_fault     <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_fault    <= 1'b0;
      case (state)
        S_IDLE: begin
          // Ops with neither load nor store set are accepted and silently dropped.
          if (accept && is_mem) begin
            if (misaligned) begin
              o_misalign <= 1'b1;
            end else begin
              state       <= S_REQ;
              op_load     <= i_load;
              op_size     <= i_size;
              op_unsigned <= i_unsigned;
              op_off      <= i_addr[1:0];
              op_rd       <= i_rd_idx;
              o_mem_addr  <= {i_addr[XLEN-1:2], 2'b00};
              o_mem_wen   <= ~i_load;
              o_mem_wdata <= i_load ? '0 : lane_wdata;
              o_mem_wstrb <= i_load ? 4'b0000 : lane_wstrb;
            end
          end
        end
        S_REQ: begin
          if (i_mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            state <= S_IDLE;
            if (i_mem_rsp_err) begin
              o_fault <= 1'b1;
            end else if (op_load) begin
              o_wb_valid  <= 1'b1;
              o_wb_rd_idx <= op_rd;
              o_wb_data   <= load_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Self-checking bench for core_lsu_ctrl: scoreboard queues for bus requests and
// writebacks, directed vectors plus random aligned traffic.
module tb_core_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_load;
  logic        i_store;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd_idx;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_rsp_valid;
  logic        i_mem_rsp_err;
  logic [31:0] i_mem_rdata;
  logic        o_mem_rsp_ready;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd_idx;
  logic [31:0] o_wb_data;
  logic        o_misalign;
  logic        o_fault;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // {addr[31:0], wen, wdata[31:0], wstrb[3:0]} and {rd[4:0], data[31:0]}
  logic [68:0] req_q[$];
  logic [36:0] wb_q[$];

  logic        cur_ld;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [1:0]  cur_off;
  logic [4:0]  cur_rd;

  core_lsu_ctrl #(.XLEN(32), .RFIDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_load(i_load), .i_store(i_store), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rd_idx(i_rd_idx),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_err(i_mem_rsp_err), .i_mem_rdata(i_mem_rdata),
    .o_mem_rsp_ready(o_mem_rsp_ready), .o_wb_valid(o_wb_valid),
    .o_wb_rd_idx(o_wb_rd_idx), .o_wb_data(o_wb_data), .o_misalign(o_misalign),
    .o_fault(o_fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return a[0];
    if (sz[1]) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) begin
      case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  // ---------------- writeback scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_wb_valid === 1'b1) begin
      total++;
      if (wb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, none expected", o_wb_rd_idx, o_wb_data);
      end else begin
        logic [36:0] e;
        e = wb_q.pop_front();
        if ({o_wb_rd_idx, o_wb_data} !== e) begin
          bad++;
          $display("FAIL wb_data: got rd=%0d data=%h exp rd=%0d data=%h",
                   o_wb_rd_idx, o_wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_valid = 0; i_load = 0; i_store = 0; i_size = 0; i_unsigned = 0;
    i_addr = 0; i_wdata = 0; i_rd_idx = 0;
    i_mem_req_ready = 0; i_mem_rsp_valid = 0; i_mem_rsp_err = 0; i_mem_rdata = 0;
  endtask

  // Presents one op for a single accepted cycle; returns on the next falling edge.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int n = 0;
    while (o_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL ready_timeout: got o_ready=%b exp 1", o_ready);
    end
    i_valid = 1; i_load = ld; i_store = st; i_size = sz; i_unsigned = uns;
    i_addr = a; i_wdata = d; i_rd_idx = rd;
    cur_ld = ld; cur_size = sz; cur_uns = uns; cur_off = a[1:0]; cur_rd = rd;
    if ((ld | st) && !m_misaligned(sz, a))
      req_q.push_back({a[31:2], 2'b00, ~ld, ld ? 32'h0 : m_wdata(sz, d),
                       ld ? 4'b0000 : m_wstrb(sz, a[1:0])});
    @(negedge clk);
    i_valid = 0; i_load = 0; i_store = 0;
  endtask

  // Checks the pending request (stable while stalled) and handshakes it.
  task automatic req_phase(input int stall);
    int n = 0;
    logic [68:0] e;
    while (o_mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n == 20 || req_q.size() == 0) begin
      bad++;
      $display("FAIL req_timeout: got req_valid=%b queued=%0d exp 1", o_mem_req_valid, req_q.size());
      return;
    end
    e = req_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      total++;
      if (o_mem_req_valid !== 1'b1 || o_mem_addr !== e[68:37] || o_mem_wen !== e[36] ||
          o_mem_wstrb !== e[3:0] || (e[36] && o_mem_wdata !== e[35:4])) begin
        bad++;
        $display("FAIL req_fields(cyc %0d): got v=%b a=%h wen=%b wd=%h st=%b exp a=%h wen=%b wd=%h st=%b",
                 i, o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
                 e[68:37], e[36], e[35:4], e[3:0]);
      end
      if (i == stall) i_mem_req_ready = 1;
      @(negedge clk);
    end
    i_mem_req_ready = 0;
  endtask

  // Delivers the response, then checks the next-cycle pulses and return to IDLE.
  task automatic rsp_phase(input logic [31:0] rdata, input logic err);
    total++;
    if (o_mem_rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_ready: got %b exp 1", o_mem_rsp_ready);
    end
    i_mem_rsp_valid = 1; i_mem_rsp_err = err; i_mem_rdata = rdata;
    if (cur_ld && !err) wb_q.push_back({cur_rd, m_load(cur_size, cur_uns, cur_off, rdata)});
    @(negedge clk);
    i_mem_rsp_valid = 0; i_mem_rsp_err = 0;
    total++;
    if (o_fault !== err || o_wb_valid !== (cur_ld & ~err) || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_result: got fault=%b wb=%b ready=%b exp fault=%b wb=%b ready=1",
               o_fault, o_wb_valid, o_ready, err, cur_ld & ~err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if (o_ready !== 1 || o_mem_req_valid !== 0 || o_mem_rsp_ready !== 0 || o_wb_valid !== 0 ||
        o_misalign !== 0 || o_fault !== 0 || o_mem_wstrb !== 0 || o_mem_wen !== 0 ||
        o_mem_addr !== 0 || o_wb_data !== 0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b rq=%b rs=%b wb=%b mis=%b flt=%b st=%b wen=%b a=%h wd=%h s=%0d exp rdy=1 others 0",
               o_ready, o_mem_req_valid, o_mem_rsp_ready, o_wb_valid, o_misalign, o_fault,
               o_mem_wstrb, o_mem_wen, o_mem_addr, o_wb_data, dbg_state);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    // lw, zero-wait: writeback exactly three cycles after accept
    issue(1, 0, 2'b10, 0, 32'h1000, 32'h0, 5'd7);
    req_phase(0);
    rsp_phase(32'hDEADBEEF, 0);
    total++;
    if (o_wb_data !== 32'hDEADBEEF || o_wb_rd_idx !== 5'd7) begin
      bad++;
      $display("FAIL lw_const: got %h rd=%0d exp deadbeef rd=7", o_wb_data, o_wb_rd_idx);
    end
    issue(1, 0, 2'b00, 0, 32'h1003, 32'h0, 5'd3);
    req_phase(0);
    rsp_phase(32'h80FF1234, 0);
    total++;
    if (o_wb_data !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL lb_const: got %h exp ffffff80", o_wb_data);
    end
    issue(1, 0, 2'b01, 1, 32'h1002, 32'h0, 5'd0);
    req_phase(0);
    rsp_phase(32'h80FF1234, 0);
    total++;
    if (o_wb_data !== 32'h000080FF || o_wb_rd_idx !== 5'd0) begin
      bad++;
      $display("FAIL lhu_const: got %h rd=%0d exp 000080ff rd=0", o_wb_data, o_wb_rd_idx);
    end
    issue(0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD, 5'd9);
    total++;
    if (o_mem_addr !== 32'h2000 || o_mem_wdata !== 32'hABCDABCD || o_mem_wstrb !== 4'b1100 ||
        o_mem_wen !== 1'b1) begin
      bad++;
      $display("FAIL sh_const: got a=%h wd=%h st=%b wen=%b exp a=00002000 wd=abcdabcd st=1100 wen=1",
               o_mem_addr, o_mem_wdata, o_mem_wstrb, o_mem_wen);
    end
    req_phase(0);
    rsp_phase(32'h0, 0);
  endtask

  task automatic test_misalign();
    issue(1, 0, 2'b10, 0, 32'h1002, 32'h0, 5'd1);
    total++;
    if (o_misalign !== 1 || o_mem_req_valid !== 0 || o_ready !== 1) begin
      bad++;
      $display("FAIL misalign_w: got mis=%b rq=%b rdy=%b exp 1 0 1", o_misalign, o_mem_req_valid, o_ready);
    end
    // new op accepted in the same cycle as the pulse
    issue(1, 0, 2'b10, 0, 32'h1004, 32'h0, 5'd2);
    total++;
    if (o_misalign !== 0 || o_mem_req_valid !== 1) begin
      bad++;
      $display("FAIL misalign_b2b: got mis=%b rq=%b exp 0 1", o_misalign, o_mem_req_valid);
    end
    req_phase(0);
    rsp_phase(32'h01234567, 0);
    issue(0, 1, 2'b01, 0, 32'h3001, 32'h55AA, 5'd0);
    total++;
    if (o_misalign !== 1 || o_mem_req_valid !== 0) begin
      bad++;
      $display("FAIL misalign_h: got mis=%b rq=%b exp 1 0", o_misalign, o_mem_req_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_and_priority();
    issue(0, 0, 2'b10, 0, 32'h4000, 32'h0, 5'd4);
    total++;
    if (o_mem_req_valid !== 0 || o_ready !== 1 || o_misalign !== 0) begin
      bad++;
      $display("FAIL noop_drop: got rq=%b rdy=%b mis=%b exp 0 1 0", o_mem_req_valid, o_ready, o_misalign);
    end
    issue(1, 1, 2'b00, 0, 32'h4001, 32'hFFFF_FF11, 5'd12);
    req_phase(1);
    rsp_phase(32'h0000_7F00, 0);
  endtask

  task automatic test_stall_fault();
    issue(0, 1, 2'b00, 0, 32'h5003, 32'h0000_00C3, 5'd0);
    req_phase(3);
    rsp_phase(32'h0, 1);
    issue(1, 0, 2'b10, 0, 32'h5008, 32'h0, 5'd15);
    req_phase(3);
    rsp_phase(32'hCAFEF00D, 1);
  endtask

  task automatic test_reset_in_wait();
    issue(1, 0, 2'b10, 0, 32'h6000, 32'h0, 5'd20);
    req_phase(0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    i_mem_rsp_valid = 1; i_mem_rdata = 32'h1111_2222; i_mem_rsp_err = 1;
    total++;
    if (o_ready !== 1 || o_mem_rsp_ready !== 0) begin
      bad++;
      $display("FAIL rst_wait_idle: got rdy=%b rs=%b exp 1 0", o_ready, o_mem_rsp_ready);
    end
    @(negedge clk);
    i_mem_rsp_valid = 0; i_mem_rsp_err = 0;
    total++;
    if (o_wb_valid !== 0 || o_fault !== 0 || o_ready !== 1 || o_mem_req_valid !== 0) begin
      bad++;
      $display("FAIL rst_wait_late_rsp: got wb=%b flt=%b rdy=%b rq=%b exp 0 0 1 0",
               o_wb_valid, o_fault, o_ready, o_mem_req_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      logic        ld;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      ld = 1'($urandom_range(0, 1));
      issue(ld, ~ld, sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)));
      req_phase($urandom_range(0, 2));
      rsp_phase($urandom, ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_misalign();
    test_drop_and_priority();
    test_stall_fault();
    test_reset_in_wait();
    test_random();
    repeat (2) @(negedge clk);
    total++;
    if (wb_q.size() != 0 || req_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: got wb=%0d req=%0d exp 0 0", wb_q.size(), req_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
